imem_loader: RTL and testbench

//  Boot-time program loader for the one-tact MIPS core. Receives a byte

---
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: turns a length-prefixed byte stream into
// big-endian 32-bit words written from address 0, holding the core in reset until complete.
module imem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int unsigned CAP = 1 << ADDR_W;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        LOAD,
        DONE,
        ERR
    } state_t;

    state_t            state, state_nx;
    logic              accept;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [15:0]       hdr_len;
    logic              too_long;
    logic              last_byte;
    logic [23:0]       asm_q;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_cnt;

    always_comb begin
        rx_ready  = (state == HDR_HI) || (state == HDR_LO) || (state == LOAD);
        accept    = rx_valid && rx_ready;
        hdr_len   = {len_hi, rx_data};
        too_long  = 32'(hdr_len) > CAP;
        // word_cnt is one bit wider than the address so a full-capacity load never wraps
        last_byte = (byte_idx == 2'd3) && ((32'(word_cnt) + 32'd1) == 32'(len));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= HDR_HI;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            HDR_HI: if (accept) state_nx = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (hdr_len == 16'd0) state_nx = DONE;
                    else if (too_long)    state_nx = ERR;
                    else                  state_nx = LOAD;
                end
            end
            LOAD:    if (accept && last_byte) state_nx = DONE;
            DONE:    state_nx = DONE;
            ERR:     state_nx = ERR;
            default: state_nx = HDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len_hi     <= '0;
            len        <= '0;
            asm_q      <= '0;
            byte_idx   <= '0;
            word_cnt   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    HDR_HI: len_hi <= rx_data;
                    HDR_LO: len    <= hdr_len;
                    LOAD: begin
                        asm_q    <= {asm_q[15:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= {asm_q, rx_data};
                            word_cnt   <= word_cnt + (ADDR_W+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
            // An empty program releases the core straight from the header; otherwise one cycle after the last write
            if ((state == DONE) || ((state == HDR_LO) && accept && (hdr_len == 16'd0))) begin
                done    <= 1'b1;
                cpu_rst <= 1'b0;
            end
            if (state_nx == ERR) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/word streams, empty and oversize programs,
// full-capacity load, mid-load reset and trailing bytes after completion.
module tb_imem_loader;

    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          acc_n = 0;
    int          last_acc = -1;
    int          wr_n = 0;
    logic [31:0] wr_addr [0:127];
    logic [31:0] wr_data [0:127];
    int          wr_cyc  [0:127];
    int          done_cyc = -1;
    int          run_cyc  = -1;
    int          err_cyc  = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes and write pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            acc_n++;
            last_acc = cyc;
        end
        if (imem_we && wr_n < 128) begin
            wr_addr[wr_n] = 32'(imem_addr);
            wr_data[wr_n] = imem_wdata;
            wr_cyc[wr_n]  = cyc;
            wr_n++;
        end
        if (done && done_cyc < 0)     done_cyc = cyc;
        if (!cpu_rst && run_cyc < 0)  run_cyc = cyc;
        if (err && err_cyc < 0)       err_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_we",       32'(imem_we), 32'd0);
        check("rst_addr",     32'(imem_addr), 32'd0);
        check("rst_wdata",    imem_wdata, 32'd0);
        check("rst_cpu_rst",  32'(cpu_rst), 32'd1);
        check("rst_done",     32'(done), 32'd0);
        check("rst_err",      32'(err), 32'd0);
        rst      = 1'b0;
        acc_n    = 0;
        last_acc = -1;
        wr_n     = 0;
        done_cyc = -1;
        run_cyc  = -1;
        err_cyc  = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        ok       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("accept_wait", 32'(ok), 32'd1);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    endtask

    task automatic settle();
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic offer(input int n);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] full_word(input int i);
        logic [7:0] a;
        a = 8'(i);
        return {a, ~a, 8'(i * 3), 8'hC3};
    endfunction

    logic [31:0] t2_words [0:2];
    int          acc_before;
    int          wr_before;

    initial begin
        t2_words[0] = 32'h11223344;
        t2_words[1] = 32'hA5A50F0F;
        t2_words[2] = 32'hDEADBEEF;

        // Single word, back-to-back bytes
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h20080005, 0);
        check("t1_cpu_rst_during", 32'(cpu_rst), 32'd1);
        settle();
        check("t1_wr_n",    32'(wr_n), 32'd1);
        check("t1_addr",    wr_addr[0], 32'd0);
        check("t1_data",    wr_data[0], 32'h20080005);
        check("t1_we_lat",  32'(wr_cyc[0] - last_acc), 32'd1);
        check("t1_done_lat", 32'(done_cyc - wr_cyc[0]), 32'd1);
        check("t1_run_lat", 32'(run_cyc - wr_cyc[0]), 32'd1);
        check("t1_done",    32'(done), 32'd1);
        check("t1_cpu_rst", 32'(cpu_rst), 32'd0);
        check("t1_ready",   32'(rx_ready), 32'd0);
        check("t1_acc_n",   32'(acc_n), 32'd6);

        // Three words with rx_valid toggling
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        for (int i = 0; i < 3; i++) send_word(t2_words[i], 1);
        settle();
        check("t2_wr_n", 32'(wr_n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_addr%0d", i), wr_addr[i], 32'(i));
            check($sformatf("t2_data%0d", i), wr_data[i], t2_words[i]);
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu_rst", 32'(cpu_rst), 32'd0);

        // Empty program
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        settle();
        check("t3_wr_n",     32'(wr_n), 32'd0);
        check("t3_done_lat", 32'(done_cyc - last_acc), 32'd1);
        check("t3_run_lat",  32'(run_cyc - last_acc), 32'd1);
        check("t3_ready",    32'(rx_ready), 32'd0);
        check("t3_cpu_rst",  32'(cpu_rst), 32'd0);

        // Oversize header: 65 words with 64-word capacity
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h41, 0);
        settle();
        check("t4_err",     32'(err), 32'd1);
        check("t4_err_lat", 32'(err_cyc - last_acc), 32'd1);
        check("t4_ready",   32'(rx_ready), 32'd0);
        check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t4_done",    32'(done), 32'd0);
        offer(4);
        check("t4_acc_n",   32'(acc_n), 32'd2);
        check("t4_wr_n",    32'(wr_n), 32'd0);

        // Exactly full capacity
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        for (int i = 0; i < 64; i++) send_word(full_word(i), 0);
        settle();
        check("t4b_wr_n", 32'(wr_n), 32'd64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("t4b_addr%0d", i), wr_addr[i], 32'(i));
            check($sformatf("t4b_data%0d", i), wr_data[i], full_word(i));
        end
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_err",  32'(err), 32'd0);

        // Reset in the middle of the second word, then a fresh stream
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h01234567, 0);
        send_byte(8'h89, 0);
        send_byte(8'hAB, 0);
        check("t5_wr_before", 32'(wr_n), 32'd1);
        check("t5_data_before", wr_data[0], 32'h01234567);
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'hCAFEF00D, 0);
        settle();
        check("t5_wr_n", 32'(wr_n), 32'd1);
        check("t5_addr", wr_addr[0], 32'd0);
        check("t5_data", wr_data[0], 32'hCAFEF00D);
        check("t5_done", 32'(done), 32'd1);

        // Trailing bytes after completion
        acc_before = acc_n;
        wr_before  = wr_n;
        offer(8);
        settle();
        check("t6_acc_n", 32'(acc_n), 32'(acc_before));
        check("t6_wr_n",  32'(wr_n), 32'(wr_before));
        check("t6_ready", 32'(rx_ready), 32'd0);
        check("t6_done",  32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
